// File: rtl/stream_accumulator.sv
// -----------------------------------------------------------------------------
// ripple_carry_adder
//   W-bit ripple-carry adder built from a chain of full adders.
//   a_i, b_i : W-bit operands
//   cin_i    : carry into bit 0
//   sum_o    : W-bit sum (modulo 2^W)
//   cout_o   : carry out of the most significant bit
//
// stream_accumulator
//   Sums a stream of N-bit unsigned operands in frames of up to LEN operands.
//   A frame ends after LEN operands or earlier on in_last. The frame sum, the
//   operand count and a sticky carry-out flag are then presented on a
//   registered output handshake. The next frame starts once the result has
//   been taken.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake; in_data is the operand and
//                          in_last marks the final operand of a frame
//   out_valid/out_ready  : result handshake
//   out_sum              : frame sum modulo 2^ACC_W
//   out_count            : operands in the frame (1..LEN)
//   out_ovf              : at least one adder carry-out occurred in the frame
// -----------------------------------------------------------------------------

module ripple_carry_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] carry;

  assign carry[0] = cin_i;

  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign sum_o[gi]    = a_i[gi] ^ b_i[gi] ^ carry[gi];
    assign carry[gi+1]  = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
  end

  assign cout_o = carry[W];

endmodule

module stream_accumulator #(
  parameter int N     = 8,
  parameter int ACC_W = N + 2,
  parameter int LEN   = 4,
  localparam int CW   = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CW-1:0]    out_count,
  output logic             out_ovf
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_out_q, ovf_out_d;

  logic [ACC_W-1:0]   add_sum;
  logic               add_cout;
  logic               accept;
  logic               frame_end;
  logic [CW-1:0]      cnt_inc;

  ripple_carry_adder #(
    .W (ACC_W)
  ) u_adder (
    .a_i    (acc_q),
    .b_i    (ACC_W'(in_data)),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Handshake outputs decode registered state only, never inputs.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);

  assign accept    = in_valid && (state_q == ACCUM);
  assign cnt_inc   = cnt_q + 1'b1;
  // cnt_q holds operands already taken, so LEN-1 means this accept is the LEN-th.
  assign frame_end = accept && (in_last || (cnt_q == CW'(LEN - 1)));

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    sum_d     = sum_q;
    count_d   = count_q;
    ovf_out_d = ovf_out_q;

    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_cout;
          if (frame_end) begin
            sum_d     = add_sum;
            count_d   = cnt_inc;
            ovf_out_d = ovf_q | add_cout;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        // Result fields stay put; only the running state is cleared.
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: result registers are reset too, so outputs read zero right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sum_q     <= '0;
      count_q   <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_out_q;

endmodule

// File: tb/tb_stream_accumulator.sv
// -----------------------------------------------------------------------------
// tb_stream_accumulator
//   Drives two stream_accumulator instances with identical stimulus: one with
//   default parameters (ACC_W=10) and one with ACC_W=9 to exercise wrap and
//   overflow. A behavioural model computes the expected frame results, pushes
//   them into a per-instance queue at the frame-ending accept, and a monitor
//   compares them while each instance presents out_valid.
// -----------------------------------------------------------------------------

`timescale 1ns/1ps

module tb_stream_accumulator;

  localparam int N    = 8;
  localparam int LEN  = 4;
  localparam int CW   = $clog2(LEN + 1);
  localparam int WA   = N + 2;
  localparam int WB   = 9;

  typedef struct {
    int unsigned sum;
    int unsigned count;
    int unsigned ovf;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic [N-1:0]   in_data;
  logic           in_last;
  logic           out_ready;

  logic           in_ready_a, out_valid_a, out_ovf_a;
  logic [WA-1:0]  out_sum_a;
  logic [CW-1:0]  out_count_a;
  logic           in_ready_b, out_valid_b, out_ovf_b;
  logic [WB-1:0]  out_sum_b;
  logic [CW-1:0]  out_count_b;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Model state per width.
  int unsigned m_acc_a, m_acc_b, m_ovf_a, m_ovf_b, m_cnt;

  always #5 clk = ~clk;

  stream_accumulator u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_sum   (out_sum_a),
    .out_count (out_count_a),
    .out_ovf   (out_ovf_a)
  );

  stream_accumulator #(
    .N     (N),
    .ACC_W (WB),
    .LEN   (LEN)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_sum   (out_sum_b),
    .out_count (out_count_b),
    .out_ovf   (out_ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_acc_a = 0;
    m_acc_b = 0;
    m_ovf_a = 0;
    m_ovf_b = 0;
    m_cnt   = 0;
  endfunction

  // Offer one operand; keep in_valid high on return so back-to-back calls stream.
  task automatic send(input int unsigned d, input bit last);
    bit   accepted = 1'b0;
    bit   fin;
    int unsigned s;
    exp_t e;
    in_valid = 1'b1;
    in_data  = N'(d);
    in_last  = last;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready_a) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      check("send_timeout", 32'd0, 32'd1);
      return;
    end
    @(posedge clk);
    #1;
    s = m_acc_a + d;
    m_ovf_a |= (s >> WA) & 1;
    m_acc_a = s % (1 << WA);
    s = m_acc_b + d;
    m_ovf_b |= (s >> WB) & 1;
    m_acc_b = s % (1 << WB);
    m_cnt++;
    fin = last || (m_cnt == LEN);
    if (fin) begin
      e.count = m_cnt;
      e.sum = m_acc_a; e.ovf = m_ovf_a; q_a.push_back(e);
      e.sum = m_acc_b; e.ovf = m_ovf_b; q_b.push_back(e);
      model_clear();
      check("latency_valid_a", 32'(out_valid_a), 32'd1);
      check("latency_valid_b", 32'(out_valid_b), 32'd1);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 100; c++) begin
      if (q_a.size() == 0 && q_b.size() == 0) return;
      @(posedge clk);
    end
    check("drain_timeout", 32'(q_a.size() + q_b.size()), 32'd0);
  endtask

  // Monitor: compares presented results, checks hold stability and in_ready
  // return on the cycle after each handoff.
  bit handoff_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      handoff_prev = 1'b0;
    end else begin
      if (handoff_prev) begin
        check("post_handoff_ready_a", 32'(in_ready_a), 32'd1);
        check("post_handoff_valid_a", 32'(out_valid_a), 32'd0);
        check("post_handoff_ready_b", 32'(in_ready_b), 32'd1);
      end
      handoff_prev = 1'b0;
      if (out_valid_a) begin
        if (q_a.size() == 0) begin
          check("spurious_valid_a", 32'd1, 32'd0);
        end else begin
          check("sum_a",   32'(out_sum_a),   q_a[0].sum);
          check("count_a", 32'(out_count_a), q_a[0].count);
          check("ovf_a",   32'(out_ovf_a),   q_a[0].ovf);
          check("ready_low_a", 32'(in_ready_a), 32'd0);
          if (out_ready) begin
            void'(q_a.pop_front());
            handoff_prev = 1'b1;
          end
        end
      end
      if (out_valid_b) begin
        if (q_b.size() == 0) begin
          check("spurious_valid_b", 32'd1, 32'd0);
        end else begin
          check("sum_b",   32'(out_sum_b),   q_b[0].sum);
          check("count_b", 32'(out_count_b), q_b[0].count);
          check("ovf_b",   32'(out_ovf_b),   q_b[0].ovf);
          if (out_ready) void'(q_b.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_a", 32'(out_valid_a), 32'd0);
    check("rst_ready_a", 32'(in_ready_a), 32'd1);
    check("rst_sum_a",   32'(out_sum_a), 32'd0);
    check("rst_count_a", 32'(out_count_a), 32'd0);
    check("rst_ovf_a",   32'(out_ovf_a), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full frame, back-to-back: 100.
    send(10, 0); send(20, 0); send(30, 0); send(40, 0);
    idle(3);
    wait_drain();

    // Early termination: 12, then a fresh frame starting from zero.
    send(5, 0); send(7, 1);
    idle(3);
    send(9, 1);
    idle(3);
    wait_drain();

    // Wrap/overflow in the 9-bit instance: 253 ovf=1; 765 in the 10-bit one.
    send(255, 0); send(255, 0); send(255, 1);
    idle(3);
    send(1, 1);
    idle(3);
    wait_drain();

    // Backpressure: result held while out_ready is low; offered data ignored.
    out_ready = 1'b0;
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    in_valid = 1'b1;
    in_data  = 8'd99;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ready_a", 32'(in_ready_a), 32'd0);
      check("bp_ready_b", 32'(in_ready_b), 32'd0);
      check("bp_valid_a", 32'(out_valid_a), 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    idle(3);
    wait_drain();

    // Bubbles: 4 x 255 with idle cycles between.
    send(255, 0); idle(1);
    send(255, 0); idle(1);
    send(255, 0); idle(1);
    send(255, 0);
    idle(3);
    wait_drain();

    // Asynchronous reset mid-frame discards the partial frame.
    send(100, 0); send(50, 0);
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid_a", 32'(out_valid_a), 32'd0);
    check("arst_ready_a", 32'(in_ready_a), 32'd1);
    check("arst_sum_a",   32'(out_sum_a), 32'd0);
    check("arst_count_a", 32'(out_count_a), 32'd0);
    check("arst_ovf_b",   32'(out_ovf_b), 32'd0);
    check("arst_sum_b",   32'(out_sum_b), 32'd0);
    #2;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    send(3, 0); send(4, 0); send(5, 0); send(6, 0);
    idle(3);
    wait_drain();

    // Random frames with random gaps and random in_last.
    for (int f = 0; f < 20; f++) begin
      int unsigned len;
      len = $urandom_range(1, LEN);
      for (int k = 0; k < len; k++) begin
        send($urandom_range(0, 255), (k == len - 1) && ($urandom_range(0, 1) == 1));
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      if (m_cnt != 0) send($urandom_range(0, 255), 1);
      idle($urandom_range(1, 3));
      wait_drain();
    end

    idle(3);
    check("final_queue_a", 32'(q_a.size()), 32'd0);
    check("final_queue_b", 32'(q_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
